// File: rtl/spi_port_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_port_bank_if
// Purpose  : Bundle of the SPI pins and Z80-side shadow outputs of the
//            expander-CPLD SPI register bank.
// Ports    : SPI_SCK / SPI_NSS / SPI_MOSI / SPI_A  - host MCU SPI pins (async)
//            SPI_MISO / SPI_MISO_OE               - readback data and enable
//            CH_DATA / CH_UPD                     - committed shadows, pulses
//            FRAME_ERR / ERR_CLR                  - sticky error and its clear
// Modports : slave  - the register bank
//            master - the host / environment side
// Revision : 1.0 - initial release
// ============================================================================
interface spi_port_bank_if #(
  parameter int NUM_CH = 4,
  parameter int A_W    = 2,
  parameter int DATA_W = 40
);
  logic                       SPI_SCK;
  logic                       SPI_NSS;
  logic                       SPI_MOSI;
  logic [A_W-1:0]             SPI_A;
  logic                       SPI_MISO;
  logic                       SPI_MISO_OE;
  logic [NUM_CH*DATA_W-1:0]   CH_DATA;
  logic [NUM_CH-1:0]          CH_UPD;
  logic                       FRAME_ERR;
  logic                       ERR_CLR;

  modport slave (
    input  SPI_SCK, SPI_NSS, SPI_MOSI, SPI_A, ERR_CLR,
    output SPI_MISO, SPI_MISO_OE, CH_DATA, CH_UPD, FRAME_ERR
  );

  modport master (
    output SPI_SCK, SPI_NSS, SPI_MOSI, SPI_A, ERR_CLR,
    input  SPI_MISO, SPI_MISO_OE, CH_DATA, CH_UPD, FRAME_ERR
  );
endinterface
`default_nettype wire

// File: rtl/spi_port_bank.sv
`default_nettype none
// ============================================================================
// Module   : spi_port_bank
// Purpose  : SPI slave register bank. SPI pins are oversampled on CLK14M,
//            frames are shifted into a per-frame register and committed
//            atomically into the addressed channel shadow on NSS rise.
//            Malformed frames are dropped and raise a sticky FRAME_ERR.
// Ports    : CLK14M - sole clock
//            RST    - asynchronous active-high reset
//            bus    - spi_port_bank_if.slave (SPI pins, shadows, error flag)
// Options  : SPI_BANK_READBACK_EN - when defined, MISO returns the addressed
//            channel's last committed frame MSB first; otherwise MISO is 0.
// Revision : 1.0 - initial release
// ============================================================================
module spi_port_bank #(
  parameter int                        NUM_CH   = 4,
  parameter int                        A_W      = 2,
  parameter int                        DATA_W   = 40,
  parameter logic [NUM_CH-1:0]         INV_MASK = 4'b1000,
  parameter logic [NUM_CH*DATA_W-1:0]  INIT_VAL = '0
) (
  input wire logic         CLK14M,
  input wire logic         RST,
  spi_port_bank_if.slave   bus
);
  // Counter must hold DATA_W+1 so overlong frames saturate instead of wrapping.
  localparam int                 c_cnt_w   = $clog2(DATA_W + 2);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DATA_W);
  localparam logic [c_cnt_w-1:0] c_cnt_sat = c_cnt_w'(DATA_W + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  // Synchronisers; the third SCK/NSS stage is used only for edge detection.
  logic [2:0]        r_sck_sync;
  logic [2:0]        r_nss_sync;
  logic [1:0]        r_mosi_sync;
  logic [A_W-1:0]    r_a_s1;
  logic [A_W-1:0]    r_a_s2;

  state_t            r_state;
  logic [A_W-1:0]    r_ch;
  logic [DATA_W-1:0] r_sreg;
  logic [c_cnt_w-1:0] r_cnt;
  logic              r_oe;
  logic [NUM_CH-1:0] r_upd;
  logic              r_ferr;
  logic [DATA_W-1:0] r_shadow [NUM_CH];

  logic              w_sck_rise;
  logic              w_nss_fall;
  logic              w_nss_rise;
  logic              w_inv;
  logic [DATA_W-1:0] w_sreg_nxt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic              w_len_ok;
  logic              w_ch_ok;
  logic              w_end;
  logic              w_commit;
  logic              w_err;
  logic [NUM_CH*DATA_W-1:0] w_ch_data;

  always_ff @(posedge CLK14M or posedge RST) begin
    if (RST) begin
      r_sck_sync  <= '0;
      r_nss_sync  <= '1;   // idle-high so reset release is not seen as a frame start
      r_mosi_sync <= '0;
      r_a_s1      <= '0;
      r_a_s2      <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], bus.SPI_SCK};
      r_nss_sync  <= {r_nss_sync[1:0], bus.SPI_NSS};
      r_mosi_sync <= {r_mosi_sync[0], bus.SPI_MOSI};
      r_a_s1      <= bus.SPI_A;
      r_a_s2      <= r_a_s1;
    end
  end

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_nss_fall = ~r_nss_sync[1] & r_nss_sync[2];
  assign w_nss_rise = r_nss_sync[1] & ~r_nss_sync[2];

  always_comb begin
    w_inv = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == A_W'(i)) w_inv = INV_MASK[i];
    end
  end

  // Shift/count for this cycle, evaluated before the end-of-frame decision so
  // a coincident SCK rise and NSS rise still includes the last bit.
  assign w_sreg_nxt = w_sck_rise ? {r_sreg[DATA_W-2:0], r_mosi_sync[1] ^ w_inv} : r_sreg;
  assign w_cnt_nxt  = (w_sck_rise && (r_cnt != c_cnt_sat)) ? r_cnt + 1'b1 : r_cnt;

  assign w_len_ok = (w_cnt_nxt != '0) && (w_cnt_nxt[2:0] == 3'd0) && (w_cnt_nxt <= c_cnt_max);
  assign w_ch_ok  = (32'(r_ch) < NUM_CH);
  assign w_end    = (r_state == S_SHIFT) && w_nss_rise;
  assign w_commit = w_end && w_len_ok && w_ch_ok;
  // An empty frame (no clocks) is neither a commit nor an error.
  assign w_err    = w_end && (w_cnt_nxt != '0) && !(w_len_ok && w_ch_ok);

`ifdef SPI_BANK_READBACK_EN
  localparam int c_len_w = $clog2(DATA_W/8 + 1);

  logic               w_sck_fall;
  logic [DATA_W-1:0]  r_tx;
  logic [c_len_w-1:0] r_len [NUM_CH];
  logic [DATA_W-1:0]  w_sel_data;
  logic [c_len_w-1:0] w_sel_len;
  logic [c_len_w-1:0] w_new_len;

  assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_new_len  = c_len_w'(w_cnt_nxt >> 3);

  always_comb begin
    w_sel_data = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_a_s2 == A_W'(i)) begin
        w_sel_data = r_shadow[i];
        w_sel_len  = r_len[i];
      end
    end
  end

  // Transmit register is left-aligned so MISO is always its MSB; zeros shift
  // in behind the stored frame.
  assign bus.SPI_MISO = r_tx[DATA_W-1];
`else
  assign bus.SPI_MISO = 1'b0;
`endif

  always_ff @(posedge CLK14M or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_oe    <= 1'b0;
      r_upd   <= '0;
      r_ferr  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= INIT_VAL[i*DATA_W +: DATA_W];
      end
`ifdef SPI_BANK_READBACK_EN
      r_tx <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_len[i] <= '0;
      end
`endif
    end else begin
      r_upd <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_nss_fall) begin
            r_state <= S_SHIFT;
            r_ch    <= r_a_s2;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_oe    <= 1'b1;
`ifdef SPI_BANK_READBACK_EN
            r_tx    <= w_sel_data << (DATA_W - 8*int'(w_sel_len));
`endif
          end
        end
        S_SHIFT: begin
          r_sreg <= w_sreg_nxt;
          r_cnt  <= w_cnt_nxt;
`ifdef SPI_BANK_READBACK_EN
          if (w_sck_fall) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
`endif
          if (w_nss_rise) begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
`ifdef SPI_BANK_READBACK_EN
            r_tx    <= '0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase

      for (int i = 0; i < NUM_CH; i++) begin
        if (w_commit && (r_ch == A_W'(i))) begin
          r_shadow[i] <= w_sreg_nxt;
          r_upd[i]    <= 1'b1;
`ifdef SPI_BANK_READBACK_EN
          r_len[i]    <= w_new_len;
`endif
        end
      end

      // A new error outranks a simultaneous clear.
      if (w_err) begin
        r_ferr <= 1'b1;
      end else if (bus.ERR_CLR) begin
        r_ferr <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign w_ch_data[g*DATA_W +: DATA_W] = r_shadow[g];
  end

  assign bus.CH_DATA     = w_ch_data;
  assign bus.CH_UPD      = r_upd;
  assign bus.FRAME_ERR   = r_ferr;
  assign bus.SPI_MISO_OE = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_spi_port_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_port_bank
// Purpose  : Directed self-checking bench for spi_port_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_port_bank;
  localparam int NUM_CH = 4;
  localparam int A_W    = 2;
  localparam int DATA_W = 40;
  localparam int BANK_W = NUM_CH*DATA_W;
  localparam logic [BANK_W-1:0] INIT =
    {40'hC3C3C3C3C3, 40'h0000000000, 40'h5A5A5A5A5A, 40'h0123456789};

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [BANK_W-1:0] exp_bank;
  logic [63:0]       rx;

  spi_port_bank_if #(.NUM_CH(NUM_CH), .A_W(A_W), .DATA_W(DATA_W)) bus ();

  spi_port_bank #(
    .NUM_CH   (NUM_CH),
    .A_W      (A_W),
    .DATA_W   (DATA_W),
    .INV_MASK (4'b1000),
    .INIT_VAL (INIT)
  ) dut (
    .CLK14M (clk),
    .RST    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BANK_W-1:0] got, input logic [BANK_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One SPI frame, MSB first, mode 0: 3 clk low / 3 clk high per bit.
  // SPI_A switches to a_mid after the third bit. MISO is sampled just before
  // each rising SCK into rx.
  task automatic spi_frame(input string tag, input logic [A_W-1:0] a, input logic [A_W-1:0] a_mid,
                           input int nbits, input logic [63:0] data,
                           input logic [NUM_CH-1:0] exp_upd, input logic exp_err,
                           output logic [63:0] rx_o);
    rx_o = '0;
    @(negedge clk);
    bus.SPI_A = a;
    repeat (2) @(negedge clk);
    bus.SPI_NSS = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_oe_pre"}, BANK_W'(bus.SPI_MISO_OE), '0);
    @(negedge clk);
    check({tag, "_oe_on"}, BANK_W'(bus.SPI_MISO_OE), BANK_W'(1));
    @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.SPI_MOSI = data[i];
      if (i == nbits - 4) bus.SPI_A = a_mid;
      repeat (3) @(negedge clk);
      rx_o = {rx_o[62:0], bus.SPI_MISO};
      bus.SPI_SCK = 1'b1;
      repeat (3) @(negedge clk);
      bus.SPI_SCK = 1'b0;
    end
    repeat (3) @(negedge clk);
    bus.SPI_NSS = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("%s_upd%0d", tag, k), BANK_W'(bus.CH_UPD),
            (k == 3) ? BANK_W'(exp_upd) : '0);
      if (k == 2) check({tag, "_oe_hold"}, BANK_W'(bus.SPI_MISO_OE), BANK_W'(1));
      if (k == 3) begin
        check({tag, "_oe_off"}, BANK_W'(bus.SPI_MISO_OE), '0);
        check({tag, "_err"}, BANK_W'(bus.FRAME_ERR), BANK_W'(exp_err));
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst          = 1'b1;
    bus.SPI_SCK  = 1'b0;
    bus.SPI_NSS  = 1'b1;
    bus.SPI_MOSI = 1'b0;
    bus.SPI_A    = '0;
    bus.ERR_CLR  = 1'b0;
    exp_bank     = INIT;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    check("rst_data", bus.CH_DATA, INIT);
    check("rst_upd",  BANK_W'(bus.CH_UPD), '0);
    check("rst_err",  BANK_W'(bus.FRAME_ERR), '0);
    check("rst_oe",   BANK_W'(bus.SPI_MISO_OE), '0);
    check("rst_miso", BANK_W'(bus.SPI_MISO), '0);

    spi_frame("f24", 2'd1, 2'd1, 24, 64'hA53C0F, 4'b0010, 1'b0, rx);
    exp_bank[1*DATA_W +: DATA_W] = 40'h0000A53C0F;
    check("f24_data", bus.CH_DATA, exp_bank);

    spi_frame("inv40", 2'd3, 2'd3, 40, 64'h0, 4'b1000, 1'b0, rx);
    exp_bank[3*DATA_W +: DATA_W] = 40'hFFFFFFFFFF;
    check("inv40_data", bus.CH_DATA, exp_bank);

    spi_frame("empty", 2'd0, 2'd0, 0, 64'h0, 4'b0000, 1'b0, rx);
    check("empty_data", bus.CH_DATA, exp_bank);

    // Clear held through the error: error must win, then the clear applies.
    bus.ERR_CLR = 1'b1;
    spi_frame("f13", 2'd0, 2'd0, 13, 64'h1ABC, 4'b0000, 1'b1, rx);
    check("f13_cleared", BANK_W'(bus.FRAME_ERR), '0);
    bus.ERR_CLR = 1'b0;
    check("f13_data", bus.CH_DATA, exp_bank);

    spi_frame("f48", 2'd0, 2'd0, 48, 64'h123456789ABC, 4'b0000, 1'b1, rx);
    check("f48_data", bus.CH_DATA, exp_bank);
    bus.ERR_CLR = 1'b1;
    @(negedge clk);
    bus.ERR_CLR = 1'b0;
    check("errclr", BANK_W'(bus.FRAME_ERR), '0);

    // 64 clocks would wrap a non-saturating counter back to zero.
    spi_frame("f64", 2'd1, 2'd1, 64, 64'hFFFF000012345678, 4'b0000, 1'b1, rx);
    check("f64_data", bus.CH_DATA, exp_bank);

    spi_frame("amid", 2'd2, 2'd0, 8, 64'h7E, 4'b0100, 1'b1, rx);
    exp_bank[2*DATA_W +: DATA_W] = 40'h000000007E;
    check("amid_data", bus.CH_DATA, exp_bank);

    spi_frame("beef", 2'd2, 2'd2, 16, 64'hBEEF, 4'b0100, 1'b1, rx);
    exp_bank[2*DATA_W +: DATA_W] = 40'h000000BEEF;
    check("beef_data", bus.CH_DATA, exp_bank);

    spi_frame("rb", 2'd2, 2'd2, 16, 64'h1234, 4'b0100, 1'b1, rx);
    exp_bank[2*DATA_W +: DATA_W] = 40'h0000001234;
    check("rb_data", bus.CH_DATA, exp_bank);
`ifdef SPI_BANK_READBACK_EN
    check("rb_miso", BANK_W'(rx), BANK_W'(64'hBEEF));
`else
    check("rb_miso", BANK_W'(rx), '0);
`endif

    // Reset in the middle of an 8-bit frame to channel 1.
    @(negedge clk);
    bus.SPI_A = 2'd1;
    repeat (2) @(negedge clk);
    bus.SPI_NSS = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.SPI_MOSI = 1'b1;
      repeat (3) @(negedge clk);
      bus.SPI_SCK = 1'b1;
      repeat (3) @(negedge clk);
      bus.SPI_SCK = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.SPI_NSS = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rstmid_upd%0d", k), BANK_W'(bus.CH_UPD), '0);
    end
    check("rstmid_data", bus.CH_DATA, INIT);
    check("rstmid_err",  BANK_W'(bus.FRAME_ERR), '0);
    check("rstmid_oe",   BANK_W'(bus.SPI_MISO_OE), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
